// File: rtl/pmic_pkg.sv
// Shared PMIC definitions: PWM soft-start FSM encoding and default sizing.
package pmic_pkg;

    localparam int unsigned PWM_CNT_W     = 8;
    localparam int unsigned SOFTSTART_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_softstart_if.sv
// Control/status bundle of the soft-start PWM generator.
interface pwm_softstart_if
    import pmic_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
);

    logic             tick;
    logic             enable;
    logic             fault;
    logic [CNT_W-1:0] duty_target;
    logic             pwm_out;
    logic [CNT_W-1:0] duty_now;
    pwm_state_t       state;
    logic             ramp_done;

    modport master (
        output tick, enable, fault, duty_target,
        input  pwm_out, duty_now, state, ramp_done
    );

    modport slave (
        input  tick, enable, fault, duty_target,
        output pwm_out, duty_now, state, ramp_done
    );

endinterface

// File: rtl/pwm_timebase.sv
// PWM period counter advanced by the slow-clock tick; flags the period boundary.
module pwm_timebase
    import pmic_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             run_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] pcnt_o,
    output logic             boundary_c
);

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (clear_i) begin
            pcnt_d = '0;
        end else if (run_i && tick_i) begin
            pcnt_d = pcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // Boundary is the tick that wraps the counter from max back to 0.
    assign boundary_c = tick_i && run_i && (pcnt_q == {CNT_W{1'b1}});
    assign pcnt_o     = pcnt_q;

endmodule

// File: rtl/pwm_softstart.sv
// Soft-start PWM: ramps duty to the target, then tracks it at period boundaries; latched fault.
module pwm_softstart
    import pmic_pkg::*;
#(
    parameter int unsigned CNT_W    = PWM_CNT_W,
    parameter int unsigned RAMP_DIV = SOFTSTART_DIV
) (
    input logic            clk,
    input logic            rst_n,
    pwm_softstart_if.slave bus
);

    localparam int unsigned     RDIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RDIV_W-1:0] RDIV_LAST = RDIV_W'(RAMP_DIV - 1);

    pwm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [RDIV_W-1:0] rdiv_q, rdiv_d;
    logic              pwm_q, pwm_d;
    logic              ramp_done_q;

    logic [CNT_W-1:0]  pcnt;
    logic              boundary_c;
    logic              active_c;
    logic              kill_c;

    assign active_c = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign kill_c   = bus.fault || !bus.enable;

    pwm_timebase #(
        .CNT_W (CNT_W)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_i     (bus.tick),
        .run_i      (active_c),
        .clear_i    (kill_c || !active_c),
        .pcnt_o     (pcnt),
        .boundary_c (boundary_c)
    );

    // Next-state: fault beats enable drop, which beats boundary/ramp updates.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        rdiv_d  = rdiv_q;
        pwm_d   = active_c && !kill_c && (pcnt < duty_q);

        if (bus.fault) begin
            state_d = ST_FAULT;
            duty_d  = '0;
            rdiv_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    rdiv_d = '0;
                    if (bus.enable) state_d = ST_RAMP;
                end
                ST_RAMP, ST_RUN: begin
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                        rdiv_d  = '0;
                    end else if (boundary_c) begin
                        if (state_q == ST_RUN) begin
                            duty_d = bus.duty_target;
                        end else if (duty_q >= bus.duty_target) begin
                            duty_d  = bus.duty_target;
                            state_d = ST_RUN;
                        end else if (rdiv_q == RDIV_LAST) begin
                            // duty_q < target here, so the step cannot wrap
                            duty_d = duty_q + CNT_W'(1);
                            rdiv_d = '0;
                        end else begin
                            rdiv_d = rdiv_q + RDIV_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (!bus.enable) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            rdiv_q      <= '0;
            pwm_q       <= 1'b0;
            ramp_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            rdiv_q      <= rdiv_d;
            pwm_q       <= pwm_d;
            ramp_done_q <= (state_d == ST_RUN);
        end
    end

    assign bus.pwm_out   = pwm_q;
    assign bus.duty_now  = duty_q;
    assign bus.state     = state_q;
    assign bus.ramp_done = ramp_done_q;

endmodule

// File: tb/tb_pwm_softstart.sv
// Bench for pwm_softstart: directed scenarios plus randomized run against a behavioural model.
module tb_pwm_softstart;
    import pmic_pkg::*;

    localparam int unsigned CW          = 4;
    localparam int unsigned RD          = 2;
    localparam int          PMAX        = 15;
    localparam int          PERIOD_CLKS = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pwm_softstart_if #(.CNT_W(CW)) bus ();

    pwm_softstart #(
        .CNT_W    (CW),
        .RAMP_DIV (RD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: mode 0..3, applied duty, position in period, boundaries seen during the ramp.
    int m_mode, m_duty, m_pos, m_nb;
    bit m_pwm, m_bnd;

    task automatic model_reset();
        m_mode = 0; m_duty = 0; m_pos = 0; m_nb = 0; m_pwm = 1'b0; m_bnd = 1'b0;
    endtask

    // One clk: tick every third cycle; model advances alongside the DUT.
    task automatic clk_cycle();
        int n_mode, n_duty, n_pos, n_nb, tgt;
        bit act, bnd, n_pwm, tk;
        tk       = (cyc % 3 == 2);
        bus.tick = tk;
        tgt      = int'(bus.duty_target);
        act      = (m_mode == 1) || (m_mode == 2);
        bnd      = tk && act && (m_pos == PMAX);
        n_pwm    = act && bus.enable && !bus.fault && (m_pos < m_duty);
        n_mode = m_mode; n_duty = m_duty; n_pos = m_pos; n_nb = m_nb;
        if (bus.fault) begin
            n_mode = 3; n_duty = 0; n_pos = 0; n_nb = 0;
        end else if (m_mode == 0) begin
            if (bus.enable) n_mode = 1;
        end else if (m_mode == 3) begin
            if (!bus.enable) n_mode = 0;
        end else if (!bus.enable) begin
            n_mode = 0; n_duty = 0; n_pos = 0; n_nb = 0;
        end else begin
            if (tk) n_pos = (m_pos + 1) % (PMAX + 1);
            if (bnd) begin
                if (m_mode == 2) begin
                    n_duty = tgt;
                end else if (m_duty >= tgt) begin
                    n_duty = tgt; n_mode = 2;
                end else begin
                    n_nb   = m_nb + 1;
                    n_duty = n_nb / RD;
                end
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_duty = n_duty; m_pos = n_pos; m_nb = n_nb;
        m_pwm = n_pwm; m_bnd = bnd;
        cyc++;
    endtask

    task automatic run_to_boundary(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk_cycle();
            if (m_bnd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_period(output int cnt);
        cnt = 0;
        for (int i = 0; i < PERIOD_CLKS; i++) begin
            clk_cycle();
            cnt += int'(bus.pwm_out);
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.fault = 1'b0; bus.duty_target = '0; bus.tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pwm_out, bus.duty_now, bus.state, bus.ramp_done} !== '0) begin
            failures++;
            $display("FAIL reset_init: pwm=%0b duty=%0d state=%0d done=%0b, want all 0",
                     bus.pwm_out, bus.duty_now, bus.state, bus.ramp_done);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        bus.enable = 1'b1; bus.duty_target = 4'd9;
        for (int i = 0; i < 200; i++) clk_cycle();
        checks++;
        if (bus.state !== ST_RAMP || int'(bus.duty_now) !== m_duty || m_duty == 0) begin
            failures++;
            $display("FAIL reset_pre_ramp: state=%0d duty=%0d, want RAMP duty=%0d (nonzero)",
                     bus.state, bus.duty_now, m_duty);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pwm_out, bus.duty_now, bus.state, bus.ramp_done} !== '0) begin
            failures++;
            $display("FAIL reset_async: pwm=%0b duty=%0d state=%0d done=%0b, want all 0",
                     bus.pwm_out, bus.duty_now, bus.state, bus.ramp_done);
        end
        bus.enable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_softstart();
        bit ok;
        int cnt;
        bus.duty_target = 4'd5;
        bus.enable      = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            run_to_boundary(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL softstart_timeout: boundary %0d not reached", k);
            end
            if (k <= 10) begin
                checks++;
                if (int'(bus.duty_now) !== k / 2 || bus.state !== ST_RAMP || bus.ramp_done !== 1'b0) begin
                    failures++;
                    $display("FAIL softstart_step%0d: duty=%0d state=%0d done=%0b, want duty=%0d RAMP done=0",
                             k, bus.duty_now, bus.state, bus.ramp_done, k / 2);
                end
            end else begin
                checks++;
                if (bus.duty_now !== 4'd5 || bus.state !== ST_RUN || bus.ramp_done !== 1'b1) begin
                    failures++;
                    $display("FAIL softstart_run: duty=%0d state=%0d done=%0b, want 5 RUN 1",
                             bus.duty_now, bus.state, bus.ramp_done);
                end
            end
        end
        count_period(cnt);
        checks++;
        if (cnt !== 5 * 3) begin
            failures++;
            $display("FAIL softstart_pwm: high clks=%0d, want %0d", cnt, 5 * 3);
        end
    endtask

    task automatic test_target_change();
        bit ok;
        int cnt;
        cnt = 0;
        for (int i = 0; i < PERIOD_CLKS; i++) begin
            if (i == 20) bus.duty_target = 4'd12;
            clk_cycle();
            cnt += int'(bus.pwm_out);
        end
        checks++;
        if (cnt !== 5 * 3) begin
            failures++;
            $display("FAIL change_cur_period: high clks=%0d, want %0d", cnt, 5 * 3);
        end
        count_period(cnt);
        checks++;
        if (cnt !== 12 * 3 || bus.duty_now !== 4'd12) begin
            failures++;
            $display("FAIL change_next_period: high clks=%0d duty=%0d, want %0d duty=12",
                     cnt, bus.duty_now, 12 * 3);
        end
        bus.duty_target = 4'd0;
        run_to_boundary(ok);
        count_period(cnt);
        checks++;
        if (!ok || cnt !== 0 || bus.duty_now !== 4'd0 || bus.state !== ST_RUN) begin
            failures++;
            $display("FAIL change_zero: ok=%0b high clks=%0d duty=%0d state=%0d, want 0 0 RUN",
                     ok, cnt, bus.duty_now, bus.state);
        end
    endtask

    task automatic test_target_below();
        bit ok;
        bus.enable = 1'b0;
        clk_cycle();
        checks++;
        if (bus.state !== ST_IDLE || bus.duty_now !== '0 || bus.pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL below_disable: state=%0d duty=%0d pwm=%0b, want IDLE 0 0",
                     bus.state, bus.duty_now, bus.pwm_out);
        end
        bus.enable = 1'b1; bus.duty_target = 4'd9;
        for (int k = 0; k < 12 && bus.duty_now != 4'd4; k++) run_to_boundary(ok);
        checks++;
        if (bus.duty_now !== 4'd4 || bus.state !== ST_RAMP) begin
            failures++;
            $display("FAIL below_reach4: duty=%0d state=%0d, want 4 RAMP", bus.duty_now, bus.state);
        end
        for (int i = 0; i < 10; i++) clk_cycle();
        bus.duty_target = 4'd2;
        run_to_boundary(ok);
        checks++;
        if (!ok || bus.duty_now !== 4'd2 || bus.state !== ST_RUN || bus.ramp_done !== 1'b1) begin
            failures++;
            $display("FAIL below_clamp: duty=%0d state=%0d done=%0b, want 2 RUN 1",
                     bus.duty_now, bus.state, bus.ramp_done);
        end
    endtask

    task automatic test_fault();
        bit ok;
        int high;
        bus.duty_target = 4'd10;
        run_to_boundary(ok);
        for (int i = 0; i < 60 && bus.pwm_out !== 1'b1; i++) clk_cycle();
        checks++;
        if (bus.pwm_out !== 1'b1) begin
            failures++;
            $display("FAIL fault_pre_pwm: pwm=%0b, want 1", bus.pwm_out);
        end
        bus.fault = 1'b1;
        clk_cycle();
        bus.fault = 1'b0;
        checks++;
        if (bus.pwm_out !== 1'b0 || bus.state !== ST_FAULT || bus.duty_now !== '0 || bus.ramp_done !== 1'b0) begin
            failures++;
            $display("FAIL fault_entry: pwm=%0b state=%0d duty=%0d done=%0b, want 0 FAULT 0 0",
                     bus.pwm_out, bus.state, bus.duty_now, bus.ramp_done);
        end
        high = 0;
        for (int i = 0; i < 60; i++) begin
            clk_cycle();
            high += int'(bus.pwm_out);
        end
        checks++;
        if (bus.state !== ST_FAULT || high !== 0) begin
            failures++;
            $display("FAIL fault_latch: state=%0d pwm high clks=%0d, want FAULT 0", bus.state, high);
        end
        bus.enable = 1'b0;
        clk_cycle();
        checks++;
        if (bus.state !== ST_IDLE) begin
            failures++;
            $display("FAIL fault_exit: state=%0d, want IDLE", bus.state);
        end
        bus.enable = 1'b1; bus.duty_target = 4'd3;
        clk_cycle();
        checks++;
        if (bus.state !== ST_RAMP || bus.duty_now !== '0) begin
            failures++;
            $display("FAIL fault_rearm: state=%0d duty=%0d, want RAMP 0", bus.state, bus.duty_now);
        end
        run_to_boundary(ok);
        run_to_boundary(ok);
        checks++;
        if (!ok || bus.duty_now !== 4'd1 || bus.state !== ST_RAMP) begin
            failures++;
            $display("FAIL fault_restart: duty=%0d state=%0d, want 1 RAMP", bus.duty_now, bus.state);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        for (int k = 0; k < 10 && bus.state != ST_RUN; k++) run_to_boundary(ok);
        for (int i = 0; i < 100 && !(m_pos == PMAX && cyc % 3 == 2); i++) clk_cycle();
        checks++;
        if (bus.state !== ST_RUN || bus.duty_now !== 4'd3 || !(m_pos == PMAX && cyc % 3 == 2)) begin
            failures++;
            $display("FAIL simul_setup: state=%0d duty=%0d, want RUN 3 before boundary",
                     bus.state, bus.duty_now);
        end
        bus.fault = 1'b1; bus.enable = 1'b0; bus.duty_target = 4'd9;
        clk_cycle();
        checks++;
        if (bus.state !== ST_FAULT || bus.duty_now !== '0 || bus.pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL simul_fault: state=%0d duty=%0d pwm=%0b, want FAULT 0 0",
                     bus.state, bus.duty_now, bus.pwm_out);
        end
        bus.fault = 1'b0;
        clk_cycle();
        checks++;
        if (bus.state !== ST_IDLE) begin
            failures++;
            $display("FAIL simul_exit: state=%0d, want IDLE", bus.state);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.enable && $urandom_range(399) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(19) == 0) bus.enable = 1'b1;
            bus.fault = ($urandom_range(599) == 0);
            if ($urandom_range(59) == 0) bus.duty_target = CW'($urandom_range(15));
            clk_cycle();
            checks++;
            if (bus.pwm_out !== m_pwm || int'(bus.duty_now) !== m_duty ||
                int'(bus.state) !== m_mode || bus.ramp_done !== (m_mode == 2)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cyc%0d: pwm=%0b duty=%0d state=%0d done=%0b, want %0b %0d %0d %0b",
                             i, bus.pwm_out, bus.duty_now, bus.state, bus.ramp_done,
                             m_pwm, m_duty, m_mode, (m_mode == 2));
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_softstart();
        test_target_change();
        test_target_below();
        test_fault();
        test_simultaneous();
        bus.enable = 1'b1; bus.duty_target = 4'd11;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
